// File: rtl/vrf_operand_read_arbiter.sv
// vrf_operand_read_arbiter
//   Per-lane VRF read arbiter sitting directly upstream of the operand queues.
//   Each operand queue presents at most one read request per cycle. Requests
//   are arbitrated per VRF bank with a round-robin pointer. The grants drive
//   single-ported bank SRAMs that have 1-cycle read latency. The returned bank
//   data is then steered back to the queue that issued the read.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i              per-queue read request (held until granted)
//   req_addr_i         per-queue lane word address; low bits select the bank
//   queue_ready_i      per-queue "can accept one more element"
//   req_gnt_o          per-queue grant, combinational, same cycle
//   operand_issued_o   per-queue "read issued", identical to req_gnt_o
//   vrf_req_o          per-bank read enable
//   vrf_addr_o         per-bank bank-local word address (0 when idle)
//   vrf_rdata_i        per-bank read data, valid one cycle after vrf_req_o
//   operand_o          per-queue returned data (0 when not valid)
//   operand_valid_o    per-queue returned data valid
module vrf_operand_read_arbiter #(
  parameter int unsigned NrBanks   = 8,
  parameter int unsigned NrQueues  = 9,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 12
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NrQueues-1:0]                           req_i,
  input  logic [NrQueues*AddrWidth-1:0]                 req_addr_i,
  input  logic [NrQueues-1:0]                           queue_ready_i,
  output logic [NrQueues-1:0]                           req_gnt_o,
  output logic [NrQueues-1:0]                           operand_issued_o,
  output logic [NrBanks-1:0]                            vrf_req_o,
  output logic [NrBanks*(AddrWidth-$clog2(NrBanks))-1:0] vrf_addr_o,
  input  logic [NrBanks*DataWidth-1:0]                  vrf_rdata_i,
  output logic [NrQueues*DataWidth-1:0]                 operand_o,
  output logic [NrQueues-1:0]                           operand_valid_o
);

  localparam int unsigned BankBits = $clog2(NrBanks);
  localparam int unsigned LocalW   = AddrWidth - BankBits;
  localparam int unsigned QIdxW    = $clog2(NrQueues);

  typedef logic [QIdxW-1:0]    qidx_t;
  typedef logic [BankBits-1:0] bank_t;

  // Round-robin pointers and return-path tags, one per bank.
  qidx_t               r_rr      [NrBanks];
  logic  [NrBanks-1:0] r_tag_vld;
  qidx_t               r_tag     [NrBanks];

  bank_t               w_bank_of [NrQueues];
  logic [NrQueues-1:0] w_elig    [NrBanks];
  logic [NrBanks-1:0]  w_bank_vld;
  qidx_t               w_bank_q  [NrBanks];

  // Bank selection and eligibility.
  always_comb begin
    for (int unsigned q = 0; q < NrQueues; q++) begin
      w_bank_of[q] = req_addr_i[q*AddrWidth +: BankBits];
    end
    for (int unsigned b = 0; b < NrBanks; b++) begin
      w_elig[b] = '0;
      for (int unsigned q = 0; q < NrQueues; q++) begin
        w_elig[b][q] = req_i[q] & queue_ready_i[q] & (w_bank_of[q] == bank_t'(b));
      end
    end
  end

  // Cyclic search from r_rr[b]. It runs in two ascending passes: first the
  // queues at or above the pointer, then the queues below it. The first hit
  // wins, which gives the same result as a modular scan without a variable
  // index.
  always_comb begin
    for (int unsigned b = 0; b < NrBanks; b++) begin
      w_bank_vld[b] = 1'b0;
      w_bank_q[b]   = '0;
      for (int unsigned q = 0; q < NrQueues; q++) begin
        if (!w_bank_vld[b] && w_elig[b][q] && (qidx_t'(q) >= r_rr[b])) begin
          w_bank_vld[b] = 1'b1;
          w_bank_q[b]   = qidx_t'(q);
        end
      end
      for (int unsigned q = 0; q < NrQueues; q++) begin
        if (!w_bank_vld[b] && w_elig[b][q] && (qidx_t'(q) < r_rr[b])) begin
          w_bank_vld[b] = 1'b1;
          w_bank_q[b]   = qidx_t'(q);
        end
      end
    end
  end

  // Grants and bank-side outputs.
  always_comb begin
    req_gnt_o  = '0;
    vrf_req_o  = w_bank_vld;
    vrf_addr_o = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      for (int unsigned q = 0; q < NrQueues; q++) begin
        if (w_bank_vld[b] && (w_bank_q[b] == qidx_t'(q))) begin
          req_gnt_o[q] = 1'b1;
          vrf_addr_o[b*LocalW +: LocalW] = req_addr_i[q*AddrWidth + BankBits +: LocalW];
        end
      end
    end
    operand_issued_o = req_gnt_o;
  end

  // Pointer update and return-path tags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tag_vld <= '0;
      for (int unsigned b = 0; b < NrBanks; b++) begin
        r_rr[b]  <= '0;
        r_tag[b] <= '0;
      end
    end else begin
      r_tag_vld <= w_bank_vld;
      for (int unsigned b = 0; b < NrBanks; b++) begin
        if (w_bank_vld[b]) begin
          r_tag[b] <= w_bank_q[b];
          r_rr[b]  <= (w_bank_q[b] == qidx_t'(NrQueues-1)) ? '0 : w_bank_q[b] + 1'b1;
        end
      end
    end
  end

  // Return steering. Each queue was granted by at most one bank, so at most
  // one tag matches per queue.
  always_comb begin
    operand_o       = '0;
    operand_valid_o = '0;
    for (int unsigned q = 0; q < NrQueues; q++) begin
      for (int unsigned b = 0; b < NrBanks; b++) begin
        if (r_tag_vld[b] && (r_tag[b] == qidx_t'(q))) begin
          operand_valid_o[q]                  = 1'b1;
          operand_o[q*DataWidth +: DataWidth] = vrf_rdata_i[b*DataWidth +: DataWidth];
        end
      end
    end
  end

endmodule

// File: tb/tb_vrf_operand_read_arbiter.sv
module tb_vrf_operand_read_arbiter;

  localparam int NB = 8;
  localparam int NQ = 9;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam int LW = 9;

  logic              clk;
  logic              rst_ni;
  logic [NQ-1:0]     req;
  logic [NQ-1:0]     rdy;
  logic [AW-1:0]     addr_a  [NQ];
  logic [DW-1:0]     rdata_a [NB];
  logic [NQ*AW-1:0]  req_addr;
  logic [NB*DW-1:0]  vrf_rdata;
  logic [NQ-1:0]     gnt, issued, valid;
  logic [NB-1:0]     vrf_req;
  logic [NB*LW-1:0]  vrf_addr;
  logic [NQ*DW-1:0]  operand;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  int      m_rr   [NB];
  bit      pend_v [NQ];
  int      pend_b [NQ];

  vrf_operand_read_arbiter #(
    .NrBanks(NB), .NrQueues(NQ), .DataWidth(DW), .AddrWidth(AW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_i           (req),
    .req_addr_i      (req_addr),
    .queue_ready_i   (rdy),
    .req_gnt_o       (gnt),
    .operand_issued_o(issued),
    .vrf_req_o       (vrf_req),
    .vrf_addr_o      (vrf_addr),
    .vrf_rdata_i     (vrf_rdata),
    .operand_o       (operand),
    .operand_valid_o (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int q = 0; q < NQ; q++) req_addr[q*AW +: AW] = addr_a[q];
    for (int b = 0; b < NB; b++) vrf_rdata[b*DW +: DW] = rdata_a[b];
  end

  // Fresh bank data every cycle.
  always @(posedge clk) begin
    #1;
    for (int b = 0; b < NB; b++) rdata_a[b] = {$urandom(), $urandom()};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Compare process: the model derives grants from the round-robin rule, using
  // modular arithmetic on addresses, and expects returns from last cycle's grants.
  always @(negedge clk) begin
    logic [NQ-1:0] e_gnt, e_valid;
    logic [NB-1:0] e_vreq;
    logic [LW-1:0] e_addr [NB];
    int            g_q [NB];
    if (!rst_ni) begin
      for (int b = 0; b < NB; b++) m_rr[b] = 0;
    end
    e_gnt = '0; e_vreq = '0;
    for (int b = 0; b < NB; b++) begin
      e_addr[b] = '0;
      g_q[b]    = -1;
      for (int k = 0; k < NQ; k++) begin
        int q;
        q = (m_rr[b] + k) % NQ;
        if (g_q[b] < 0 && req[q] && rdy[q] && (int'(addr_a[q]) % NB == b)) g_q[b] = q;
      end
      if (g_q[b] >= 0) begin
        e_gnt[g_q[b]] = 1'b1;
        e_vreq[b]     = 1'b1;
        e_addr[b]     = LW'(int'(addr_a[g_q[b]]) / NB);
      end
    end
    e_valid = '0;
    for (int q = 0; q < NQ; q++) e_valid[q] = rst_ni && pend_v[q];
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("issued", 64'(issued), 64'(e_gnt));
    chk("vrf_req", 64'(vrf_req), 64'(e_vreq));
    for (int b = 0; b < NB; b++) chk($sformatf("vrf_addr[%0d]", b), 64'(vrf_addr[b*LW +: LW]), 64'(e_addr[b]));
    chk("operand_valid", 64'(valid), 64'(e_valid));
    for (int q = 0; q < NQ; q++)
      chk($sformatf("operand[%0d]", q), operand[q*DW +: DW], e_valid[q] ? rdata_a[pend_b[q]] : 64'd0);
    for (int q = 0; q < NQ; q++) pend_v[q] = 1'b0;
    if (rst_ni) begin
      for (int b = 0; b < NB; b++) begin
        if (g_q[b] >= 0) begin
          pend_v[g_q[b]] = 1'b1;
          pend_b[g_q[b]] = b;
          m_rr[b]        = (g_q[b] + 1) % NQ;
        end
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic mid;  @(negedge clk); #1; endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; req = '0; rdy = '1;
    for (int q = 0; q < NQ; q++) addr_a[q] = '0;
    for (int b = 0; b < NB; b++) begin rdata_a[b] = '0; m_rr[b] = 0; end
    for (int q = 0; q < NQ; q++) begin pend_v[q] = 1'b0; pend_b[q] = 0; end
    mid();
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_operand_any", 64'(|operand), 64'd0);
    tick(); rst_ni = 1'b1;
    tick();

    // Single read: q0 -> addr 0x011 (bank 1, local 2).
    req = 9'h001; addr_a[0] = 12'h011;
    mid();
    chk("t1_gnt", 64'(gnt), 64'h001);
    chk("t1_vreq", 64'(vrf_req), 64'h02);
    chk("t1_vaddr1", 64'(vrf_addr[1*LW +: LW]), 64'd2);
    tick(); req = '0;
    mid();
    chk("t1_valid", 64'(valid), 64'h001);
    chk("t1_data", operand[0 +: DW], rdata_a[1]);

    // Contention on bank 3: q2 and q5 alternate.
    tick(); req = 9'h024; addr_a[2] = 12'h003; addr_a[5] = 12'h02B;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("t2_gnt", 64'(gnt), (i % 2 == 1) ? 64'h020 : 64'h004);
      if (i > 0) chk("t2_valid", 64'(valid), (i % 2 == 1) ? 64'h004 : 64'h020);
      tick();
    end
    req = '0;
    mid();
    chk("t2_last_valid", 64'(valid), 64'h020);

    // Parallel: q0..q7 each to its own bank.
    tick();
    for (int q = 0; q < 8; q++) addr_a[q] = AW'(q * 8 + q);
    req = 9'h0FF;
    mid();
    chk("t3_gnt", 64'(gnt), 64'h0FF);
    chk("t3_vreq", 64'(vrf_req), 64'hFF);
    tick(); req = '0;
    mid();
    chk("t3_valid", 64'(valid), 64'h0FF);
    chk("t3_data7", operand[7*DW +: DW], rdata_a[7]);

    // Backpressure: q4 held off for 5 cycles.
    tick(); req = 9'h010; addr_a[4] = 12'h0A2; rdy[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("t4_blocked", 64'(gnt), 64'h000);
      if (i < 4) tick();
    end
    tick(); rdy[4] = 1'b1;
    mid();
    chk("t4_gnt", 64'(gnt), 64'h010);
    tick(); req = '0;

    // Pointer wrap on bank 0: q7 moves rr[0] to 8, then q8 before q0.
    addr_a[7] = 12'h040; req = 9'h080;
    mid();
    chk("t5_gnt7", 64'(gnt), 64'h080);
    chk("t5_model_rr0", 64'(m_rr[0]), 64'd8);
    tick(); req = 9'h101; addr_a[8] = 12'h008; addr_a[0] = 12'h010;
    mid();
    chk("t5_gnt8", 64'(gnt), 64'h100);
    chk("t5_model_rr_wrapped", 64'(m_rr[0]), 64'd0);
    tick(); req = 9'h001;
    mid();
    chk("t5_gnt0", 64'(gnt), 64'h001);
    chk("t5_valid8", 64'(valid), 64'h100);
    tick(); req = '0;

    // Reset mid-flight: the grant is discarded and the pointer restarts at 0.
    req = 9'h008; addr_a[3] = 12'h018;
    mid();
    chk("t6_gnt3", 64'(gnt), 64'h008);
    #2 rst_ni = 1'b0;
    tick(); req = '0;
    mid();
    chk("t6_no_valid", 64'(valid), 64'h000);
    chk("t6_operand3", operand[3*DW +: DW], 64'd0);
    tick(); rst_ni = 1'b1;
    tick(); req = 9'h009; addr_a[0] = 12'h010; addr_a[3] = 12'h018;
    mid();
    chk("t6_post_gnt", 64'(gnt), 64'h001);
    tick(); req = 9'h008;
    mid();
    chk("t6_post_gnt3", 64'(gnt), 64'h008);
    chk("t6_post_valid0", 64'(valid), 64'h001);
    tick(); req = '0;
    mid();
    chk("t6_post_valid3", 64'(valid), 64'h008);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
